// File: rtl/double_to_float.sv
// rtl/double_to_float.sv - IEEE-754 double to single converter, round-to-nearest-even, stb/ack stream
//
// Purpose:
//   Narrows one 64-bit double operand at a time to a 32-bit float. Specials
//   (NaN, inf, zero, double denormals, overflow, deep underflow) resolve in the
//   unpack state; normal results go through round and pack; results below the
//   float normal range are shifted right one bit per cycle in denormalise
//   unless FLUSH_DENORM is set, in which case they become signed zero.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   input_a       double operand
//   input_a_stb   operand valid
//   input_a_ack   ready to accept an operand (only in get_a)
//   output_z      float result, held while output_z_stb is high
//   output_z_stb  result valid
//   output_z_ack  consumer accepts the result

module double_to_float #(
  parameter bit FLUSH_DENORM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    S_GET_A,
    S_UNPACK,
    S_DENORM,
    S_ROUND,
    S_PACK,
    S_PUT_Z
  } state_t;

  state_t              state_q, state_d;
  logic [63:0]         a_q, a_d;
  logic                s_q, s_d;
  logic signed [11:0]  fe_q, fe_d;   // float biased exponent, may go negative
  logic [23:0]         mw_q, mw_d;   // mantissa with hidden bit
  logic                g_q, g_d;     // guard
  logic                r_q, r_d;     // round
  logic                st_q, st_d;   // sticky
  logic [31:0]         z_q, z_d;     // result being assembled
  logic                ack_q, ack_d;
  logic [31:0]         oz_q, oz_d;
  logic                ostb_q, ostb_d;

  logic [10:0]         a_e;
  logic [51:0]         a_m;
  logic signed [11:0]  a_fe;

  assign a_e  = a_q[62:52];
  assign a_m  = a_q[51:0];
  // Rebias from double (1023) to float (127): 1023 - 127 = 896.
  assign a_fe = $signed({1'b0, a_e}) - 12'sd896;

  assign input_a_ack  = ack_q;
  assign output_z     = oz_q;
  assign output_z_stb = ostb_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    fe_d    = fe_q;
    mw_d    = mw_q;
    g_d     = g_q;
    r_d     = r_q;
    st_d    = st_q;
    z_d     = z_q;
    ack_d   = ack_q;
    oz_d    = oz_q;
    ostb_d  = ostb_q;

    case (state_q)
      S_GET_A: begin
        // ack is registered, so it rises one cycle after entering get_a.
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        s_d     = a_q[63];
        fe_d    = a_fe;
        mw_d    = {1'b1, a_m[51:29]};
        g_d     = a_m[28];
        r_d     = a_m[27];
        st_d    = |a_m[26:0];
        state_d = S_ROUND;
        if (a_e == 11'd2047) begin
          // NaN is forced quiet; the top payload bits carry across.
          if (a_m != 52'd0) begin
            z_d = {a_q[63], 8'hFF, 1'b1, a_m[50:29]};
          end else begin
            z_d = {a_q[63], 8'hFF, 23'd0};
          end
          state_d = S_PUT_Z;
        end else if (a_e == 11'd0) begin
          // Double denormals are far below the float range.
          z_d     = {a_q[63], 31'd0};
          state_d = S_PUT_Z;
        end else if (a_e >= 11'd1151) begin
          z_d     = {a_q[63], 8'hFF, 23'd0};
          state_d = S_PUT_Z;
        end else if (a_e < 11'd871) begin
          // Too small to round up to the smallest float denormal.
          z_d     = {a_q[63], 31'd0};
          state_d = S_PUT_Z;
        end else if (a_fe <= 12'sd0) begin
          if (FLUSH_DENORM) begin
            z_d     = {a_q[63], 31'd0};
            state_d = S_PUT_Z;
          end else begin
            state_d = S_DENORM;
          end
        end
      end

      S_DENORM: begin
        // Shift right one place per cycle until the exponent reaches 1,
        // folding the bits shifted out into guard/round/sticky.
        st_d = st_q | r_q;
        r_d  = g_q;
        g_d  = mw_q[0];
        mw_d = mw_q >> 1;
        fe_d = fe_q + 12'sd1;
        if (fe_q == 12'sd0) begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (g_q && (r_q || st_q || mw_q[0])) begin
          if (mw_q == 24'hFFFFFF) begin
            mw_d = 24'h800000;
            fe_d = fe_q + 12'sd1;
          end else begin
            mw_d = mw_q + 24'd1;
          end
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        if (fe_q >= 12'sd255) begin
          z_d = {s_q, 8'hFF, 23'd0};
        end else if (fe_q == 12'sd1 && !mw_q[23]) begin
          z_d = {s_q, 8'd0, mw_q[22:0]};
        end else begin
          // A denormal that rounded into mw[23] lands here as the smallest normal.
          z_d = {s_q, fe_q[7:0], mw_q[22:0]};
        end
        state_d = S_PUT_Z;
      end

      S_PUT_Z: begin
        if (!ostb_q) begin
          ostb_d = 1'b1;
          oz_d   = z_q;
        end else if (output_z_ack) begin
          ostb_d  = 1'b0;
          state_d = S_GET_A;
        end
      end

      default: begin
        state_d = S_GET_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GET_A;
      a_q     <= 64'd0;
      s_q     <= 1'b0;
      fe_q    <= 12'sd0;
      mw_q    <= 24'd0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      st_q    <= 1'b0;
      z_q     <= 32'd0;
      ack_q   <= 1'b0;
      oz_q    <= 32'd0;
      ostb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      fe_q    <= fe_d;
      mw_q    <= mw_d;
      g_q     <= g_d;
      r_q     <= r_d;
      st_q    <= st_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      oz_q    <= oz_d;
      ostb_q  <= ostb_d;
    end
  end

endmodule

// File: tb/tb_double_to_float.sv
// tb/tb_double_to_float.sv - self-checking bench for double_to_float

module tb_double_to_float;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [63:0] a_in = 64'd0;
  logic        a_stb = 1'b0;
  logic        a_ack;
  logic [31:0] z;
  logic        z_stb;
  logic        z_ack = 1'b0;

  logic [63:0] f_a = 64'd0;
  logic        f_stb = 1'b0;
  logic        f_ack;
  logic [31:0] f_z;
  logic        f_zstb;
  logic        f_zack = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  double_to_float #(.FLUSH_DENORM(1'b0)) dut (
    .clk(clk), .rst(rst),
    .input_a(a_in), .input_a_stb(a_stb), .input_a_ack(a_ack),
    .output_z(z), .output_z_stb(z_stb), .output_z_ack(z_ack)
  );

  double_to_float #(.FLUSH_DENORM(1'b1)) dut_f (
    .clk(clk), .rst(rst),
    .input_a(f_a), .input_a_stb(f_stb), .input_a_ack(f_ack),
    .output_z(f_z), .output_z_stb(f_zstb), .output_z_ack(f_zack)
  );

  typedef struct {
    logic [63:0] a;
    logic [31:0] z;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: round the exact value sig * 2^(e-1075) to a multiple of the
  // float quantum (2^(ef-150) for normals, 2^-149 for denormals) by integer
  // division with half-to-even, then assemble the float fields.
  function automatic void ref_model(input logic [63:0] a, input bit flush,
                                    output logic [31:0] zr, output int lat);
    logic        s;
    int          e, ef, shift;
    logic [51:0] m;
    logic [63:0] sig, q, rem, half;
    s  = a[63];
    e  = int'(a[62:52]);
    m  = a[51:0];
    ef = e - 896;
    lat = 2;
    if (e == 2047) begin
      zr = (m != 52'd0) ? {s, 8'hFF, 1'b1, m[50:29]} : {s, 8'hFF, 23'd0};
    end else if (e == 0 || ef < -25 || (flush && ef < 1)) begin
      zr = {s, 31'd0};
    end else if (ef >= 255) begin
      zr = {s, 8'hFF, 23'd0};
    end else begin
      sig   = {11'd0, 1'b1, m};
      shift = (ef >= 1) ? 29 : 30 - ef;
      lat   = (ef >= 1) ? 4 : 5 - ef;
      q     = sig >> shift;
      rem   = sig & ((64'd1 << shift) - 64'd1);
      half  = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (ef >= 1) begin
        if (q == (64'd1 << 24)) begin
          q  = 64'd1 << 23;
          ef = ef + 1;
        end
        zr = (ef >= 255) ? {s, 8'hFF, 23'd0} : {s, 8'(ef), q[22:0]};
      end else begin
        zr = {s, q[30:0]};
      end
    end
  endfunction

  // Offer one operand, wait for accept, then count cycles until the result strobe.
  task automatic run_op(input bit use_f, input logic [63:0] av,
                        output logic [31:0] zv, output int lat, output bit ok);
    @(negedge clk);
    if (use_f) begin f_a = av; f_stb = 1'b1; end
    else       begin a_in = av; a_stb = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (use_f ? f_ack : a_ack) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    zv  = 32'd0;
    lat = 0;
    if (!ok) begin
      f_stb = 1'b0; a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    f_stb = 1'b0; a_stb = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (use_f ? f_zstb : z_stb) begin ok = 1'b1; break; end
    end
    zv = use_f ? f_z : z;
  endtask

  task automatic take_out(input bit use_f);
    @(negedge clk);
    if (use_f) f_zack = 1'b1; else z_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("stb_drop", {63'd0, (use_f ? f_zstb : z_stb)}, 64'd0);
    @(negedge clk);
    f_zack = 1'b0; z_ack = 1'b0;
  endtask

  task automatic do_vec(input bit use_f, input string name, input logic [63:0] av,
                        input logic [31:0] ez, input int elat);
    logic [31:0] zv;
    int          lat;
    bit          ok;
    run_op(use_f, av, zv, lat, ok);
    chk({name, "_done"}, {63'd0, ok}, 64'd1);
    if (ok) begin
      chk({name, "_z"}, {32'd0, zv}, {32'd0, ez});
      chk({name, "_lat"}, 64'(lat), 64'(elat));
      take_out(use_f);
    end
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] ez, zv;
    int          elat, lat;
    bit          ok;
    logic [63:0] av, rnd;
    int          sel, e;

    vecs[0]  = '{64'h3FF0000000000000, 32'h3F800000, 4};
    vecs[1]  = '{64'h400921FB54442D18, 32'h40490FDB, 4};
    vecs[2]  = '{64'h47EFFFFFE0000000, 32'h7F7FFFFF, 4};
    vecs[3]  = '{64'h47EFFFFFF0000000, 32'h7F800000, 4};
    vecs[4]  = '{64'h47F0000000000000, 32'h7F800000, 2};
    vecs[5]  = '{64'h36A0000000000000, 32'h00000001, 27};
    vecs[6]  = '{64'h3690000000000000, 32'h00000000, 28};
    vecs[7]  = '{64'h3690000000000001, 32'h00000001, 28};
    vecs[8]  = '{64'h7FF8000000000000, 32'h7FC00000, 2};
    vecs[9]  = '{64'hFFF0000000000000, 32'hFF800000, 2};
    vecs[10] = '{64'h8000000000000000, 32'h80000000, 2};
    vecs[11] = '{64'h0000000000000001, 32'h00000000, 2};
    vecs[12] = '{64'hC000000000000000, 32'hC0000000, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {63'd0, a_ack}, 64'd0);
    chk("rst_stb", {63'd0, z_stb}, 64'd0);
    chk("rst_z", {32'd0, z}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ack_before_edge1", {63'd0, a_ack}, 64'd0);
    @(posedge clk);
    #1;
    chk("ack_after_edge1", {63'd0, a_ack}, 64'd1);

    // Table vectors
    foreach (vecs[i]) begin
      do_vec(1'b0, $sformatf("vec%0d", i), vecs[i].a, vecs[i].z, vecs[i].lat);
    end

    // Flush variant
    do_vec(1'b1, "flush_denorm", 64'h36A0000000000000, 32'h00000000, 2);
    do_vec(1'b1, "flush_one", 64'h3FF0000000000000, 32'h3F800000, 4);

    // Output stall: result and strobes must hold, no new accept
    run_op(1'b0, 64'h400921FB54442D18, zv, lat, ok);
    chk("stall_done", {63'd0, ok}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_stb", {63'd0, z_stb}, 64'd1);
      chk("stall_z", {32'd0, z}, 64'h40490FDB);
      chk("stall_ack", {63'd0, a_ack}, 64'd0);
    end
    take_out(1'b0);
    chk("z_kept_after_xfer", {32'd0, z}, 64'h40490FDB);

    // Reset in the middle of denormalise
    @(negedge clk);
    a_in = 64'h36A0000000000000;
    a_stb = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_ack) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("mid_accept", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
    a_stb = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_stb", {63'd0, z_stb}, 64'd0);
    chk("mid_rst_z", {32'd0, z}, 64'd0);
    chk("mid_rst_ack", {63'd0, a_ack}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_vec(1'b0, "after_rst", 64'h3FF0000000000000, 32'h3F800000, 4);

    // Random operands against the reference model
    for (int n = 0; n < 340; n++) begin
      bit use_f;
      use_f = (n >= 300);
      rnd = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        av = rnd;
      end else begin
        if (sel <= 5)      e = $urandom_range(860, 1160);
        else if (sel <= 7) e = $urandom_range(866, 900);
        else if (sel == 8) e = $urandom_range(1140, 1155);
        else               e = ($urandom_range(0, 1) != 0) ? 2047 : 0;
        av = {rnd[63], 11'(e), rnd[51:0]};
        if ($urandom_range(0, 3) == 0) av[28:0] = 29'h10000000;
        if ($urandom_range(0, 5) == 0) av[51:29] = 23'h7FFFFF;
      end
      ref_model(av, use_f, ez, elat);
      run_op(use_f, av, zv, lat, ok);
      chk("rand_done", {63'd0, ok}, 64'd1);
      if (ok) begin
        checks++;
        if (zv !== ez || lat != elat) begin
          failures++;
          $display("FAIL rand a=%h z=%h exp_z=%h lat=%0d exp_lat=%0d flush=%0d",
                   av, zv, ez, lat, elat, use_f);
        end
        take_out(use_f);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
